dmem_resp_port: RTL and testbench

- Data-memory slave that sits directly downstream of the riscv_core data port (mem_d_*).
- Accepts core read, write and cache-maintenance requests, then services them from an internal word SRAM over a fixed-latency pipeline.
- Returns in-order ack / data / error / resp_tag to the core.
- Used as the bench and FPGA data memory for the cacheable window.

---
 rtl/dmem_pkg.sv | 34 +++
 rtl/dmem_sram_bytewe.sv | 27 ++
 rtl/dmem_resp_port.sv | 146 ++++++++++++++
 tb/tb_dmem_resp_port.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory response port: request op classes and the
// entry carried down the fixed-latency read/write response pipeline.
package dmem_pkg;

    localparam int TAG_W = 11;

    typedef enum logic [1:0] {
        OP_READ,
        OP_WRITE,
        OP_MAINT,
        OP_ERR
    } op_e;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic             err;
        logic             rd;
        logic [31:0]      data;
    } pipe_entry_t;

    // Maintenance is a whole-memory operation, so only reads and writes are range checked.
    function automatic op_e decode_op(input logic rd, input logic wr, input logic maint,
                                      input logic in_range);
        logic [1:0] n_ops;
        n_ops = {1'b0, rd} + {1'b0, wr} + {1'b0, maint};
        if (n_ops > 2'd1) return OP_ERR;
        if (maint)        return OP_MAINT;
        if (!in_range)    return OP_ERR;
        if (rd)           return OP_READ;
        return OP_WRITE;
    endfunction

endpackage

// File: rtl/dmem_sram_bytewe.sv
// Single-port word SRAM with per-byte write enables and a registered read port.
// Contents and read register are deliberately not reset.
module dmem_sram_bytewe #(
    parameter int WORDS  = 4096,
    parameter int ADDR_W = 12
) (
    input  logic              clk_i,
    input  logic              re_i,
    input  logic [3:0]        we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
        if (re_i) rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_resp_port.sv
// Data-memory slave for the core data port: decodes requests, services reads and
// writes over a fixed-latency pipeline and blocks for multi-cycle maintenance ops.
module dmem_resp_port
    import dmem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
    parameter int          MEM_WORDS    = 4096,
    parameter int          LATENCY      = 2,
    parameter int          MAINT_CYCLES = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      mem_addr_i,
    input  logic [31:0]      mem_data_wr_i,
    input  logic             mem_rd_i,
    input  logic [3:0]       mem_wr_i,
    input  logic             mem_cacheable_i,
    input  logic [TAG_W-1:0] mem_req_tag_i,
    input  logic             mem_invalidate_i,
    input  logic             mem_writeback_i,
    input  logic             mem_flush_i,
    output logic [31:0]      mem_data_rd_o,
    output logic             mem_accept_o,
    output logic             mem_ack_o,
    output logic             mem_error_o,
    output logic [TAG_W-1:0] mem_resp_tag_o
);

    localparam int          IDX_W     = $clog2(MEM_WORDS);
    localparam int          CNT_W     = $clog2(MAINT_CYCLES);
    localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_WORDS);

    typedef enum logic {ST_IDLE, ST_MAINT} state_e;

    state_e           state_q;
    logic             accept_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [TAG_W-1:0] maint_tag_q;
    pipe_entry_t      pipe_q [LATENCY];
    pipe_entry_t      pipe_d [LATENCY];

    logic        is_maint;
    logic        req;
    logic        xfer;
    logic        in_range;
    logic        maint_done;
    logic [31:0] offset;
    logic [31:0] sram_rdata;
    op_e         op;
    logic        unused_cacheable;

    assign unused_cacheable = mem_cacheable_i;

    assign is_maint = mem_invalidate_i | mem_writeback_i | mem_flush_i;
    assign req      = mem_rd_i | (|mem_wr_i) | is_maint;
    assign xfer     = req & accept_q;
    assign offset   = mem_addr_i - BASE_ADDR;
    assign in_range = (mem_addr_i >= BASE_ADDR) && (offset < MEM_BYTES);
    assign op       = decode_op(mem_rd_i, |mem_wr_i, is_maint, in_range);

    assign cnt_d      = cnt_q - CNT_W'(1);
    assign maint_done = (state_q == ST_MAINT) && (cnt_d == '0);

    dmem_sram_bytewe #(
        .WORDS  (MEM_WORDS),
        .ADDR_W (IDX_W)
    ) u_sram (
        .clk_i   (clk_i),
        .re_i    (xfer && (op == OP_READ)),
        .we_i    ((xfer && (op == OP_WRITE)) ? mem_wr_i : 4'h0),
        .addr_i  (offset[IDX_W+1:2]),
        .wdata_i (mem_data_wr_i),
        .rdata_o (sram_rdata)
    );

    // Accept drops for the whole maintenance window and returns on the edge that issues its ack.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            accept_q    <= 1'b0;
            cnt_q       <= '0;
            maint_tag_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    accept_q <= 1'b1;
                    if (xfer && (op == OP_MAINT)) begin
                        state_q     <= ST_MAINT;
                        accept_q    <= 1'b0;
                        cnt_q       <= CNT_W'(MAINT_CYCLES - 1);
                        maint_tag_q <= mem_req_tag_i;
                    end
                end
                ST_MAINT: begin
                    cnt_q <= cnt_d;
                    if (maint_done) begin
                        state_q  <= ST_IDLE;
                        accept_q <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    accept_q <= 1'b0;
                end
            endcase
        end
    end

    // Payload fields only move with a valid entry so the outputs hold between acks;
    // read data joins the entry one stage after the SRAM sampled it.
    always_comb begin
        pipe_d          = pipe_q;
        pipe_d[0].valid = 1'b0;
        if (xfer && (op != OP_MAINT)) begin
            pipe_d[0] = '{valid: 1'b1, tag: mem_req_tag_i, err: (op == OP_ERR),
                          rd: (op == OP_READ), data: '0};
        end
        for (int k = 1; k < LATENCY; k++) begin
            pipe_d[k].valid = pipe_q[k-1].valid;
            if (pipe_q[k-1].valid) begin
                pipe_d[k] = pipe_q[k-1];
                if (k == 1) pipe_d[k].data = pipe_q[0].rd ? sram_rdata : '0;
            end
        end
        if (maint_done) begin
            pipe_d[LATENCY-1] = '{valid: 1'b1, tag: maint_tag_q, err: 1'b0, rd: 1'b0, data: '0};
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int k = 0; k < LATENCY; k++) pipe_q[k] <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign mem_accept_o   = accept_q;
    assign mem_ack_o      = pipe_q[LATENCY-1].valid;
    assign mem_error_o    = pipe_q[LATENCY-1].err;
    assign mem_resp_tag_o = pipe_q[LATENCY-1].tag;
    assign mem_data_rd_o  = ((LATENCY == 1) && pipe_q[0].rd) ? sram_rdata
                                                              : pipe_q[LATENCY-1].data;

endmodule

// File: tb/tb_dmem_resp_port.sv
// Directed bench for dmem_resp_port: hand-computed responses for reads, writes,
// errors, maintenance blocking and reset while a response is in flight.
module tb_dmem_resp_port;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_data_wr_i;
    logic        mem_rd_i;
    logic [3:0]  mem_wr_i;
    logic        mem_cacheable_i;
    logic [10:0] mem_req_tag_i;
    logic        mem_invalidate_i;
    logic        mem_writeback_i;
    logic        mem_flush_i;
    logic [31:0] mem_data_rd_o;
    logic        mem_accept_o;
    logic        mem_ack_o;
    logic        mem_error_o;
    logic [10:0] mem_resp_tag_o;

    int testsRun    = 0;
    int testsFailed = 0;

    dmem_resp_port dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .mem_addr_i       (mem_addr_i),
        .mem_data_wr_i    (mem_data_wr_i),
        .mem_rd_i         (mem_rd_i),
        .mem_wr_i         (mem_wr_i),
        .mem_cacheable_i  (mem_cacheable_i),
        .mem_req_tag_i    (mem_req_tag_i),
        .mem_invalidate_i (mem_invalidate_i),
        .mem_writeback_i  (mem_writeback_i),
        .mem_flush_i      (mem_flush_i),
        .mem_data_rd_o    (mem_data_rd_o),
        .mem_accept_o     (mem_accept_o),
        .mem_ack_o        (mem_ack_o),
        .mem_error_o      (mem_error_o),
        .mem_resp_tag_o   (mem_resp_tag_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // maint = {invalidate, writeback, flush}
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic rd, input logic [3:0] wr,
                                 input logic [10:0] tag, input logic [2:0] maint);
        mem_addr_i       = addr;
        mem_data_wr_i    = wdata;
        mem_rd_i         = rd;
        mem_wr_i         = wr;
        mem_cacheable_i  = 1'b1;
        mem_req_tag_i    = tag;
        mem_invalidate_i = maint[2];
        mem_writeback_i  = maint[1];
        mem_flush_i      = maint[0];
    endtask

    task automatic clearInputs();
        applyStimulus(32'h0, 32'h0, 1'b0, 4'h0, 11'h0, 3'b000);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", name, observed, expected);
        end
    endtask

    task automatic checkAck(input string name, input logic [10:0] tag, input logic err,
                            input logic [31:0] data);
        checkOutput({name, " ack"}, 32'(mem_ack_o), 32'h1);
        checkOutput({name, " tag"}, 32'(mem_resp_tag_o), 32'(tag));
        checkOutput({name, " err"}, 32'(mem_error_o), 32'(err));
        checkOutput({name, " data"}, mem_data_rd_o, data);
    endtask

    task automatic checkIdleZero(input string name);
        checkOutput({name, " ack"}, 32'(mem_ack_o), 32'h0);
        checkOutput({name, " tag"}, 32'(mem_resp_tag_o), 32'h0);
        checkOutput({name, " err"}, 32'(mem_error_o), 32'h0);
        checkOutput({name, " data"}, mem_data_rd_o, 32'h0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clearInputs();
        rst_i = 1'b0;
        repeat (3) tick();
        checkOutput("reset accept", 32'(mem_accept_o), 32'h0);
        checkIdleZero("reset");
        rst_i = 1'b1;
        tick();
        checkOutput("accept after reset", 32'(mem_accept_o), 32'h1);

        // Write then read
        applyStimulus(32'h8000_0010, 32'h1234_5678, 1'b0, 4'hF, 11'd5, 3'b000);
        checkOutput("wr accept", 32'(mem_accept_o), 32'h1);
        tick();
        clearInputs();
        checkOutput("wr no early ack", 32'(mem_ack_o), 32'h0);
        tick();
        checkAck("wr resp", 11'd5, 1'b0, 32'h0);
        applyStimulus(32'h8000_0010, 32'h0, 1'b1, 4'h0, 11'd6, 3'b000);
        tick();
        clearInputs();
        tick();
        checkAck("rd resp", 11'd6, 1'b0, 32'h1234_5678);
        tick();
        checkOutput("ack single pulse", 32'(mem_ack_o), 32'h0);

        // Byte strobe with write-before-read on consecutive cycles
        applyStimulus(32'h8000_0020, 32'hFFFF_FFFF, 1'b0, 4'hF, 11'd7, 3'b000);
        tick();
        applyStimulus(32'h8000_0020, 32'h0000_00AA, 1'b0, 4'h1, 11'd8, 3'b000);
        tick();
        applyStimulus(32'h8000_0020, 32'h0, 1'b1, 4'h0, 11'd10, 3'b000);
        checkAck("preload resp", 11'd7, 1'b0, 32'h0);
        tick();
        clearInputs();
        checkAck("strobe wr resp", 11'd8, 1'b0, 32'h0);
        tick();
        checkAck("strobe rd resp", 11'd10, 1'b0, 32'hFFFF_FFAA);
        tick();

        // Back-to-back reads
        applyStimulus(32'h8000_0010, 32'h0, 1'b1, 4'h0, 11'd1, 3'b000);
        checkOutput("b2b accept 1", 32'(mem_accept_o), 32'h1);
        tick();
        applyStimulus(32'h8000_0020, 32'h0, 1'b1, 4'h0, 11'd2, 3'b000);
        checkOutput("b2b accept 2", 32'(mem_accept_o), 32'h1);
        tick();
        applyStimulus(32'h8000_0010, 32'h0, 1'b1, 4'h0, 11'd3, 3'b000);
        checkOutput("b2b accept 3", 32'(mem_accept_o), 32'h1);
        checkAck("b2b resp 1", 11'd1, 1'b0, 32'h1234_5678);
        tick();
        applyStimulus(32'h8000_0020, 32'h0, 1'b1, 4'h0, 11'd4, 3'b000);
        checkOutput("b2b accept 4", 32'(mem_accept_o), 32'h1);
        checkAck("b2b resp 2", 11'd2, 1'b0, 32'hFFFF_FFAA);
        tick();
        clearInputs();
        checkAck("b2b resp 3", 11'd3, 1'b0, 32'h1234_5678);
        tick();
        checkAck("b2b resp 4", 11'd4, 1'b0, 32'hFFFF_FFAA);
        tick();
        checkOutput("b2b drained", 32'(mem_ack_o), 32'h0);

        // Out of range read, then out of range write must not alias word 0
        applyStimulus(32'h7FFF_FFFC, 32'h0, 1'b1, 4'h0, 11'd9, 3'b000);
        tick();
        clearInputs();
        tick();
        checkAck("oor rd", 11'd9, 1'b1, 32'h0);
        tick();
        applyStimulus(32'h8000_0000, 32'hCAFE_F00D, 1'b0, 4'hF, 11'd11, 3'b000);
        tick();
        applyStimulus(32'h8000_4000, 32'hDEAD_BEEF, 1'b0, 4'hF, 11'd12, 3'b000);
        tick();
        applyStimulus(32'h8000_0000, 32'h0, 1'b1, 4'h0, 11'd13, 3'b000);
        checkAck("word0 wr", 11'd11, 1'b0, 32'h0);
        tick();
        clearInputs();
        checkAck("oor wr", 11'd12, 1'b1, 32'h0);
        tick();
        checkAck("word0 rd", 11'd13, 1'b0, 32'hCAFE_F00D);
        tick();

        // Conflicting op classes
        applyStimulus(32'h8000_0010, 32'h0, 1'b1, 4'hF, 11'd14, 3'b000);
        tick();
        clearInputs();
        tick();
        checkAck("rd+wr err", 11'd14, 1'b1, 32'h0);
        applyStimulus(32'h8000_0010, 32'h0, 1'b1, 4'h0, 11'd15, 3'b001);
        tick();
        clearInputs();
        checkOutput("rd+flush no maint", 32'(mem_accept_o), 32'h1);
        tick();
        checkAck("rd+flush err", 11'd15, 1'b1, 32'h0);
        applyStimulus(32'h8000_0010, 32'h0, 1'b1, 4'h0, 11'd16, 3'b000);
        tick();
        clearInputs();
        tick();
        checkAck("post-err rd", 11'd16, 1'b0, 32'h1234_5678);
        tick();

        // Flush blocks accept; a read presented meanwhile waits
        applyStimulus(32'h8000_0000, 32'h0, 1'b0, 4'h0, 11'h7FF, 3'b001);
        checkOutput("flush accept", 32'(mem_accept_o), 32'h1);
        tick();
        applyStimulus(32'h8000_0010, 32'h0, 1'b1, 4'h0, 11'd20, 3'b000);
        for (int k = 1; k <= 7; k++) begin
            checkOutput("maint accept low", 32'(mem_accept_o), 32'h0);
            checkOutput("maint no ack", 32'(mem_ack_o), 32'h0);
            tick();
        end
        checkAck("flush resp", 11'h7FF, 1'b0, 32'h0);
        checkOutput("accept after maint", 32'(mem_accept_o), 32'h1);
        tick();
        clearInputs();
        checkOutput("held rd no early ack", 32'(mem_ack_o), 32'h0);
        tick();
        checkAck("held rd resp", 11'd20, 1'b0, 32'h1234_5678);
        tick();

        // Reset while a read is in flight
        applyStimulus(32'h8000_0010, 32'h0, 1'b1, 4'h0, 11'd21, 3'b000);
        checkOutput("pre-reset accept", 32'(mem_accept_o), 32'h1);
        tick();
        clearInputs();
        rst_i = 1'b0;
        #1;
        checkOutput("mid reset accept", 32'(mem_accept_o), 32'h0);
        checkIdleZero("mid reset");
        tick();
        tick();
        rst_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checkIdleZero("post reset");
        end
        applyStimulus(32'h8000_0020, 32'h0, 1'b1, 4'h0, 11'd22, 3'b000);
        checkOutput("post reset accept", 32'(mem_accept_o), 32'h1);
        tick();
        clearInputs();
        tick();
        checkAck("first rd after reset", 11'd22, 1'b0, 32'hFFFF_FFAA);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
